mux8_scan_sequencer: RTL
========================

Name: mux8_scan_sequencer

Overview:
- Sequencer that sits upstream of the 8:1 select tree. It drives select lines s2..s0 through channels 0..7 in order.
- After each select change it waits a programmable number of cycles for the tree to settle, then samples the tree output y back.
- It assembles the eight sampled bits into an 8-bit word and reports completion with a one-cycle valid pulse and a busy flag.
- Turns the purely combinational channel selector into a periodic parallel snapshot of eight 1-bit sources.

Parameters:
- SETTLE_CYCLES, 2: cycles each select value is held before sampling. Legal range 1..15.
- CNT_W, 4: width of the settle counter. Must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled scan request; acted on only in IDLE.
- y_in  input  1  output of the 8:1 select tree, sampled by this block.
- s0  output  1  select bit 0 (LSB) to the tree.
- s1  output  1  select bit 1 to the tree.
- s2  output  1  select bit 2 (MSB) to the tree.
- data  output  8  assembled word; bit k = y_in sampled while the select equals k.
- valid  output  1  one-cycle pulse; data is new this cycle.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE.
  - {s2,s1,s0}=3'b000, settle counter=0.
  - Internal shift word=0, data=8'h00, valid=0, busy=0.
  - Any scan in progress is abandoned; partial bits are discarded.
- All outputs are registered. s2..s0 come directly from a 3-bit channel register sel.
- FSM has three states: IDLE, SCAN, DONE.
- IDLE:
  - sel=0, valid=0, busy=0.
  - start=1 at an edge moves to SCAN: sel=0, cnt=0, busy=1.
- SCAN, at each edge:
  - If cnt != SETTLE_CYCLES-1: cnt++.
  - Else: sample y_in into bit sel of the shift word and clear cnt.
    - If sel != 7: sel++.
    - If sel == 7: go to DONE. In the same edge, data is loaded with the full word including the bit just sampled, and valid=1.
- DONE (exactly one cycle):
  - valid=1, busy=1, sel holds 7.
  - Next edge: go to IDLE with sel=0, valid=0, busy=0.
- Timing:
  - Each channel is held for exactly SETTLE_CYCLES cycles.
  - Start is accepted at edge E0. Channel k is sampled at edge E((k+1)*SETTLE_CYCLES).
  - valid is high in the cycle following edge E(8*SETTLE_CYCLES).
  - busy is high for 8*SETTLE_CYCLES+1 cycles.
- Start handling:
  - start while busy (SCAN or DONE) is ignored. It is not queued.
  - start held high continuously gives back-to-back scans separated by one IDLE cycle.
- Hold rules:
  - data holds its value between completions. It changes only on the edge entering DONE, or on reset.
  - The shift word is not cleared between scans. Every bit is overwritten during each full scan.
- Sampling:
  - y_in is sampled only at the final settle edge of each channel. Changes on y_in at other times have no effect.
- SETTLE_CYCLES=1: the select advances every cycle, and each channel is sampled at the edge ending the cycle it is selected.

Optional Feature:
- Macro: MUX8_SCAN_CONTINUOUS_EN.
- Defined:
  - DONE goes directly to SCAN with sel=0, cnt=0, busy=1. IDLE is never re-entered once the first start is accepted.
  - valid pulses every 8*SETTLE_CYCLES+1 cycles.
  - Only rst returns the block to IDLE.
- Undefined: behaviour exactly as above (single-shot per start).

Test Plan:
- Reset check: assert rst mid-SCAN (at sel=3) -> outputs are immediately s2..s0=000, data=00, valid=0, busy=0. On release, the block stays IDLE until start.
- Basic scan, SETTLE_CYCLES=2: model the tree with sources i0..i7 = 1,0,1,0,0,1,0,1, pulse start one cycle -> data=8'hA5 with valid high for exactly one cycle, 16 cycles after the start edge. busy is high 17 cycles.
- Select sequence: monitor {s2,s1,s0} during a scan -> 0,0,1,1,...,7,7 (each value held 2 cycles), then 0 in IDLE.
- Ignored start: pulse start again at sel=4 mid-scan -> no restart. Exactly one valid pulse. data matches the first request.
- Source change between scans: run a scan with all sources=1 -> data=8'hFF. Set all sources=0 and wait 20 cycles without start -> data still FF. Run a second scan -> data=8'h00.
- Continuous mode (MUX8_SCAN_CONTINUOUS_EN defined, SETTLE_CYCLES=1): single start pulse -> valid pulses every 9 cycles, busy stays 1, data tracks the sources changed between scans.

Source files
------------

// File: rtl/mux8_scan_sequencer_if.sv
// Signal bundle between the scan sequencer (master) and the 8:1 select tree side (slave).
interface mux8_scan_sequencer_if;
  logic       start;
  logic       y_in;
  logic       s0;
  logic       s1;
  logic       s2;
  logic [7:0] data;
  logic       valid;
  logic       busy;

  modport master (
    input  start,
    input  y_in,
    output s0,
    output s1,
    output s2,
    output data,
    output valid,
    output busy
  );

  modport slave (
    output start,
    output y_in,
    input  s0,
    input  s1,
    input  s2,
    input  data,
    input  valid,
    input  busy
  );
endinterface

// File: rtl/mux8_scan_sequencer.sv
// Walks the 8:1 select tree through channels 0..7, samples y_in after settling, emits an 8-bit word.
// Define MUX8_SCAN_CONTINUOUS_EN to restart a scan immediately after each completion.
module mux8_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input logic                   clk,
  input logic                   rst,
  mux8_scan_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= 3'd0;
      cnt_q   <= '0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        sel_d  = 3'd0;
        busy_d = 1'b0;
        if (bus.start) begin
          state_d = StScan;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StScan: begin
        if (cnt_q != CntLast) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Final settle edge for this channel: capture the tree output.
          shift_d[sel_q] = bus.y_in;
          cnt_d          = '0;
          if (sel_q != 3'd7) begin
            sel_d = sel_q + 3'd1;
          end else begin
            state_d = StDone;
            data_d  = shift_d;
            valid_d = 1'b1;
          end
        end
      end
      StDone: begin
`ifdef MUX8_SCAN_CONTINUOUS_EN
        state_d = StScan;
        sel_d   = 3'd0;
        cnt_d   = '0;
        busy_d  = 1'b1;
`else
        state_d = StIdle;
        sel_d   = 3'd0;
        busy_d  = 1'b0;
`endif
      end
      default: begin
        state_d = StIdle;
        sel_d   = 3'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.s0    = sel_q[0];
  assign bus.s1    = sel_q[1];
  assign bus.s2    = sel_q[2];
  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule
